// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store request and memory write handshake bundle
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - aligning store FIFO draining to data memory
// Stores are lane-aligned at push time; loads hitting a queued word raise ld_conflict.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  store_buffer_if.slave            bus,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  output logic                     st_misalign,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mis_q, mis_d;

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];

  logic [3:0]    be_n;
  logic [31:0]   data_n;
  logic          misaligned;
  logic          full, push, wr_en, pop;
  logic [PW-1:0] off;
  logic          unused_ld_bits;

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign st_misalign   = mis_q;
  assign bus.st_ready  = !full;
  assign bus.mem_req   = !empty;
  assign push          = bus.st_valid && !full;
  assign wr_en         = push && !misaligned;
  assign pop           = !empty && bus.mem_ack;
  assign unused_ld_bits = ^ld_addr[1:0];

  always_comb begin
    be_n       = 4'b1111;
    data_n     = bus.st_data;
    misaligned = 1'b0;
    case (bus.st_size)
      2'b00: begin
        be_n   = 4'b0001 << bus.st_addr[1:0];
        data_n = {4{bus.st_data[7:0]}};
      end
      2'b01: begin
        be_n       = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        data_n     = {2{bus.st_data[15:0]}};
        misaligned = bus.st_addr[0];
      end
      default: misaligned = |bus.st_addr[1:0];
    endcase
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (wr_en) wr_d = wr_q + PW'(1);
    if (pop)   rd_d = rd_q + PW'(1);
    count_d = count_q + CW'(wr_en) - CW'(pop);
    mis_d   = push && misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  // Entry storage needs no reset: every read of it is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_q] <= bus.st_addr[31:2];
      data_mem[wr_q] <= data_n;
      be_mem[wr_q]   <= be_n;
    end
  end

  assign bus.mem_addr  = empty ? '0 : {addr_mem[rd_q], 2'b00};
  assign bus.mem_wdata = empty ? '0 : data_mem[rd_q];
  assign bus.mem_be    = empty ? '0 : be_mem[rd_q];

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    ld_conflict = 1'b0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if (({1'b0, off} < count_q) && (addr_mem[i] == ld_addr[31:2]))
        ld_conflict = 1'b1;
    end
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side counterpart of the load data register in the multicycle MIPS32 datapath. It accepts SB/SH/SW requests from the MEM stage and aligns each one into a word-addressed write with byte enables. Requests are queued in a small FIFO and drained to data memory over a req/ack handshake, so MEM is not stalled on memory write latency. It also flags loads whose word address matches a pending store, which lets the control unit stall them.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept a request; equals !full
- st_addr  in  32  byte address of the store
- st_data  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
- st_size  in  2  store size: 00 byte, 01 half, 10 word, 11 treated as word
- st_misalign  out  1  one-cycle pulse; the request accepted at the previous edge was misaligned and dropped
- mem_req  out  1  write request to data memory; equals !empty
- mem_ack  in  1  memory accepted the write
- mem_addr  out  32  word address of head entry, bits [1:0] forced to 0
- mem_wdata  out  32  lane-aligned write data of head entry
- mem_be  out  4  byte enables of head entry; bit i covers lane [8i+7:8i]
- ld_addr  in  32  byte address of the load currently in MEM
- ld_conflict  out  1  combinational; high when ld_addr[31:2] equals the word address of any valid entry
- count  out  log2(DEPTH)+1  number of valid entries
- empty  out  1  count == 0

## Operation
- Push occurs when st_valid && st_ready at a rising edge.
  - Alignment is computed at push time and is little-endian.
  - Byte: be = 1 << addr[1:0]; data[7:0] is replicated into all four lanes.
  - Half: addr[1]=0 gives be 0011; addr[1]=1 gives be 1100; data[15:0] is replicated into both halves.
  - Word: be 1111; data is passed through unchanged.
- Misaligned requests are accepted but not written: half with addr[0]=1, or word/size-11 with addr[1:0]!=0.
  - No entry is written and count is unchanged.
  - st_misalign is registered high for exactly the following cycle.
- Pop occurs when mem_req && mem_ack at a rising edge. The head pointer advances and count is decremented.
- FIFO uses circular read/write pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0. full = (count == DEPTH).
- Push and pop at the same edge: both take effect and count is unchanged. This is legal at any occupancy except full, where st_ready is low.
  - There is no bypass: a store pushed into an empty buffer cannot be written in the same cycle.
- mem_addr, mem_wdata and mem_be come from the head entry. They must stay stable while mem_req is high and mem_ack is low.
- ld_conflict compares against all valid entries, including the head being written this cycle. It is forced low when empty.
- Stores to the same address drain in program order. Entries are never merged.

## Timing
- Reset values, forced immediately on rst assertion:
  - pointers = 0, count = 0, empty = 1, st_ready = 1
  - mem_req = 0, st_misalign = 0, ld_conflict = 0
  - mem_addr, mem_wdata, mem_be = 0
- Reset during a pending write: all entries are discarded and mem_req drops asynchronously. Memory must tolerate the abandoned request.
- Latency from push at edge N to mem_req high is one cycle: mem_req is high after edge N.
- Back-to-back pops: with mem_ack held high, one entry retires per cycle.
- st_ready falls the cycle after the push that reaches DEPTH entries. It rises the cycle after the next pop.
- mem_ack while mem_req is low is ignored.
- ld_conflict has zero latency relative to ld_addr and FIFO state. The rest of the block is fully synchronous to clk.

## Test plan
- Reset then SW, addr 0x0000_1004, data 0xDEADBEEF, mem_ack low:
  - After 1 cycle: mem_req=1, mem_addr=0x1004, mem_be=1111, mem_wdata=0xDEADBEEF.
  - Outputs stay stable for 5 cycles. Ack at cycle 6 gives empty=1 on the next cycle.
- SB 0xA5 to 0x2003, then SH 0x1234 to 0x2002, mem_ack high:
  - First write: be 1000, wdata 0xA5A5A5A5.
  - Second write: be 1100, wdata 0x12341234. Both at addr 0x2000, in order.
- Fill with DEPTH stores and mem_ack low:
  - st_ready=0, count=DEPTH; a further st_valid is not accepted.
  - Ack one entry: st_ready=1 next cycle.
  - Push and ack together: count constant, and pointers wrap past DEPTH-1 with order preserved.
- SW to 0x3002 and SH to 0x3001: st_misalign pulses one cycle each, count stays 0, mem_req stays 0.
- Pending SW to 0x4000:
  - ld_addr 0x4003 gives ld_conflict=1.
  - ld_addr 0x4004 gives 0.
  - After the ack edge, ld_addr 0x4003 gives 0.
- Three entries pending with mem_req high: assert rst mid-cycle. mem_req=0 and count=0 without waiting for a clock edge; after release, a new SW drains normally.
